wb_merge: RTL and testbench

Writeback merge unit for the pipelined LEGv8 core: the single writer of the register file's write port (we3/wa3/wd3). It merges fixed-latency ALU results with variable-latency load data from the data memory. Loads are buffered in a small FIFO, and a pending-load scoreboard is kept for the hazard unit. Writes to X31 (XZR) are never forwarded to the register file.

---
 rtl/wb_merge_if.sv | 44 ++++
 rtl/wb_merge.sv | 115 +++++++++++
 tb/tb_wb_merge.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_merge_if.sv
// Bus bundle for wb_merge: ALU result port, load issue/return ports,
// register-file write port and status outputs.
//   slave  : the merge unit (consumes ALU/load traffic, drives we3/wa3/wd3/status)
//   master : the pipeline side (drives ALU/load traffic, observes outputs)
interface wb_merge_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic           alu_valid;
  logic [4:0]     alu_wa;
  logic [N-1:0]   alu_wd;
  logic           ld_issue;
  logic [4:0]     ld_issue_wa;
  logic           ld_valid;
  logic           ld_ready;
  logic [4:0]     ld_wa;
  logic [N-1:0]   ld_wd;
  logic           we3;
  logic [4:0]     wa3;
  logic [N-1:0]   wd3;
  logic [31:0]    busy;
  logic [CW-1:0]  fifo_count;
  logic           waw_err;

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    input  ld_issue, ld_issue_wa,
    input  ld_valid, ld_wa, ld_wd,
    output ld_ready,
    output we3, wa3, wd3,
    output busy, fifo_count, waw_err
  );

  modport master (
    output alu_valid, alu_wa, alu_wd,
    output ld_issue, ld_issue_wa,
    output ld_valid, ld_wa, ld_wd,
    input  ld_ready,
    input  we3, wa3, wd3,
    input  busy, fifo_count, waw_err
  );
endinterface

// File: rtl/wb_merge.sv
// Writeback merge unit: sole writer of the register file write port.
// Merges 1-cycle ALU results with variable-latency load returns; loads that
// cannot commit immediately wait in a small circular FIFO. Keeps a
// pending-load scoreboard (busy) and a sticky protocol-violation flag.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      wb_merge_if.slave (ALU in, load issue/return in, ld_ready out,
//            we3/wa3/wd3 out, busy/fifo_count/waw_err out)
module wb_merge #(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  wb_merge_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [4:0]  XZR = 5'd31;

  logic [4:0]    mem_wa [DEPTH];
  logic [N-1:0]  mem_wd [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   busy_q;
  logic          we_q;
  logic [4:0]    wa_q;
  logic [N-1:0]  wd_q;
  logic          err_q;

  logic          accept, empty, push, pop, bypass, commit, ld_commit;
  logic [4:0]    commit_wa;
  logic [N-1:0]  commit_wd;
  logic [31:0]   set_mask, clr_mask, busy_nxt;
  logic [CW-1:0] count_nxt;
  logic          err_set;

  // Ready depends on registered occupancy only.
  assign bus.ld_ready   = (count != CW'(DEPTH));
  assign bus.we3        = we_q;
  assign bus.wa3        = wa_q;
  assign bus.wd3        = wd_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count;
  assign bus.waw_err    = err_q;

  // Commit arbitration (ALU > FIFO head > bypass), FIFO control, scoreboard.
  always_comb begin
    accept    = bus.ld_valid && bus.ld_ready;
    empty     = (count == '0);
    pop       = !bus.alu_valid && !empty;
    bypass    = !bus.alu_valid && empty && accept;
    push      = accept && !bypass;
    commit    = bus.alu_valid || pop || bypass;
    ld_commit = pop || bypass;

    commit_wa = bus.alu_wa;
    commit_wd = bus.alu_wd;
    if (pop) begin
      commit_wa = mem_wa[rd_ptr];
      commit_wd = mem_wd[rd_ptr];
    end else if (bypass) begin
      commit_wa = bus.ld_wa;
      commit_wd = bus.ld_wd;
    end

    set_mask = '0;
    if (bus.ld_issue && bus.ld_issue_wa != XZR) set_mask = 32'd1 << bus.ld_issue_wa;
    clr_mask = '0;
    if (ld_commit) clr_mask = 32'd1 << commit_wa;
    // Set applied after clear so a same-cycle re-issue keeps the bit.
    busy_nxt = ((busy_q & ~clr_mask) | set_mask) & 32'h7FFF_FFFF;

    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);

    err_set = (bus.alu_valid && busy_q[bus.alu_wa] && bus.alu_wa != XZR) ||
              (bus.ld_valid && !busy_q[bus.ld_wa] && bus.ld_wa != XZR);
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr] <= bus.ld_wa;
      mem_wd[wr_ptr] <= bus.ld_wd;
    end
  end

  // Pointers, occupancy, scoreboard, error flag and register-file drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      busy_q <= busy_nxt;
      if (err_set) err_q <= 1'b1;
      we_q <= commit && (commit_wa != XZR);
      if (commit) begin
        wa_q <= commit_wa;
        wd_q <= commit_wd;
      end
    end
  end
endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed scenarios plus a randomized
// phase, all compared every cycle against a queue-based reference model.
module tb_wb_merge;
  localparam int unsigned N     = 64;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_merge_if #(.N(N), .DEPTH(DEPTH)) bus ();
  wb_merge #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
  } ld_t;

  ld_t         mq[$];
  logic [31:0] mbusy;
  logic        mwe;
  logic [4:0]  mwa;
  logic [63:0] mwd;
  logic        merr;
  bit          m_acc;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy = '0; mwe = 1'b0; mwa = '0; mwd = '0; merr = 1'b0;
  endtask

  task automatic idle_in();
    bus.alu_valid = 1'b0; bus.alu_wa = '0; bus.alu_wd = '0;
    bus.ld_issue = 1'b0; bus.ld_issue_wa = '0;
    bus.ld_valid = 1'b0; bus.ld_wa = '0; bus.ld_wd = '0;
  endtask

  task automatic offer(input logic [4:0] wa, input logic [63:0] wd);
    bus.ld_valid = 1'b1; bus.ld_wa = wa; bus.ld_wd = wd;
  endtask

  task automatic check_all();
    chk("we3", 64'(bus.we3), 64'(mwe));
    if (mwe) begin
      chk("wa3", 64'(bus.wa3), 64'(mwa));
      chk("wd3", bus.wd3, mwd);
    end
    chk("busy", 64'(bus.busy), 64'(mbusy));
    chk("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
    chk("ld_ready", 64'(bus.ld_ready), 64'(mq.size() < DEPTH));
    chk("waw_err", 64'(bus.waw_err), 64'(merr));
  endtask

  // One clock of the reference: accepted loads join the back of the
  // pending queue; the ALU wins the write port, otherwise the oldest load.
  task automatic tick();
    ld_t         e;
    bit          com, isld;
    logic [4:0]  cwa;
    logic [63:0] cwd;
    logic [31:0] nb;
    com = 0; isld = 0; cwa = '0; cwd = '0;
    m_acc = bus.ld_valid && (mq.size() < DEPTH);
    if (bus.alu_valid && mbusy[bus.alu_wa] && bus.alu_wa != 5'd31) merr = 1'b1;
    if (bus.ld_valid && !mbusy[bus.ld_wa] && bus.ld_wa != 5'd31) merr = 1'b1;
    if (m_acc) begin
      e.wa = bus.ld_wa; e.wd = bus.ld_wd;
      mq.push_back(e);
    end
    if (bus.alu_valid) begin
      com = 1; cwa = bus.alu_wa; cwd = bus.alu_wd;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      com = 1; isld = 1; cwa = e.wa; cwd = e.wd;
    end
    nb = mbusy;
    if (isld) nb[cwa] = 1'b0;
    if (bus.ld_issue && bus.ld_issue_wa != 5'd31) nb[bus.ld_issue_wa] = 1'b1;
    @(posedge clk); #1;
    mbusy = nb;
    mwe = com && (cwa != 5'd31);
    if (com) begin mwa = cwa; mwd = cwd; end
    check_all();
  endtask

  task automatic issue(input logic [4:0] wa);
    bus.ld_issue = 1'b1; bus.ld_issue_wa = wa;
    tick();
    bus.ld_issue = 1'b0;
  endtask

  initial begin
    int k;
    int got;
    logic [63:0] exp_wd [10];

    idle_in();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_we3", 64'(bus.we3), 64'd0);
    chk("rst_wa3", 64'(bus.wa3), 64'd0);
    chk("rst_wd3", bus.wd3, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_ready", 64'(bus.ld_ready), 64'd1);
    chk("rst_err", 64'(bus.waw_err), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // ALU only
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd5; bus.alu_wd = 64'h1234;
    tick();
    chk("alu_we", 64'(bus.we3), 64'd1);
    chk("alu_wa", 64'(bus.wa3), 64'd5);
    chk("alu_wd", bus.wd3, 64'h1234);
    bus.alu_wa = 5'd31;
    tick();
    chk("alu_x31_we", 64'(bus.we3), 64'd0);
    idle_in();
    tick();

    // Load bypass and scoreboard
    issue(5'd9);
    chk("busy9_set", 64'(bus.busy[9]), 64'd1);
    repeat (3) begin
      tick();
      chk("busy9_hold", 64'(bus.busy[9]), 64'd1);
    end
    offer(5'd9, 64'hDEAD);
    tick();
    idle_in();
    chk("byp_we", 64'(bus.we3), 64'd1);
    chk("byp_wa", 64'(bus.wa3), 64'd9);
    chk("byp_wd", bus.wd3, 64'hDEAD);
    chk("busy9_clr", 64'(bus.busy[9]), 64'd0);

    // Conflict and ordering: loads X1..X5 against six ALU cycles
    for (int i = 1; i <= 5; i++) issue(5'(i));
    k = 1;
    offer(5'(k), 64'hA000 + 64'(k));
    for (int c = 0; c < 6; c++) begin
      bus.alu_valid = 1'b1; bus.alu_wa = 5'(20 + c); bus.alu_wd = 64'(c);
      tick();
      if (m_acc) begin
        k++;
        if (k <= 5) offer(5'(k), 64'hA000 + 64'(k)); else bus.ld_valid = 1'b0;
      end
    end
    chk("conf_full", 64'(bus.fifo_count), 64'd4);
    chk("conf_ready", 64'(bus.ld_ready), 64'd0);
    bus.alu_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (m_acc) begin
        k++;
        if (k <= 5) offer(5'(k), 64'hA000 + 64'(k)); else bus.ld_valid = 1'b0;
      end
      chk("conf_we", 64'(bus.we3), 64'd1);
      chk("conf_order", 64'(bus.wa3), 64'(i));
      chk("conf_data", bus.wd3, 64'hA000 + 64'(i));
    end
    idle_in();

    // FIFO wrap-around: 10 loads to X10..X19 interleaved with ALU bursts
    for (int i = 0; i < 10; i++) begin
      issue(5'(10 + i));
      exp_wd[i] = {$urandom, $urandom};
    end
    k = 0; got = 0;
    offer(5'd10, exp_wd[0]);
    for (int c = 0; c < 400 && got < 10; c++) begin
      bus.alu_valid = ($urandom_range(0, 2) != 0);
      bus.alu_wa = 5'(20 + $urandom_range(0, 9));
      bus.alu_wd = {$urandom, $urandom};
      tick();
      if (m_acc) begin
        k++;
        if (k < 10) offer(5'(10 + k), exp_wd[k]); else bus.ld_valid = 1'b0;
      end
      chk("wrap_max", 64'(bus.fifo_count <= 3'(DEPTH)), 64'd1);
      if (bus.we3 && bus.wa3 >= 5'd10 && bus.wa3 <= 5'd19) begin
        chk("wrap_order", 64'(bus.wa3), 64'(10 + got));
        chk("wrap_data", bus.wd3, exp_wd[got]);
        got++;
      end
    end
    chk("wrap_all", 64'(got), 64'd10);
    idle_in();
    tick();

    // Protocol violations
    chk("err_clean", 64'(bus.waw_err), 64'd0);
    issue(5'd7);
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd7; bus.alu_wd = 64'h77;
    tick();
    idle_in();
    chk("err_set", 64'(bus.waw_err), 64'd1);
    chk("err_we", 64'(bus.we3), 64'd1);
    chk("err_wa", 64'(bus.wa3), 64'd7);
    chk("err_wd", bus.wd3, 64'h77);
    tick();
    chk("err_sticky", 64'(bus.waw_err), 64'd1);
    issue(5'd3);
    bus.ld_issue = 1'b1; bus.ld_issue_wa = 5'd3;
    offer(5'd3, 64'h33);
    tick();
    idle_in();
    chk("setwins_we", 64'(bus.wa3), 64'd3);
    chk("setwins_busy", 64'(bus.busy[3]), 64'd1);

    // Reset mid-stream with 3 queued loads
    for (int i = 0; i < 3; i++) issue(5'(11 + i));
    k = 11;
    offer(5'(k), 64'hB000 + 64'(k));
    for (int c = 0; c < 3; c++) begin
      bus.alu_valid = 1'b1; bus.alu_wa = 5'(21 + c); bus.alu_wd = 64'(c);
      tick();
      if (m_acc) begin
        k++;
        if (k <= 13) offer(5'(k), 64'hB000 + 64'(k)); else bus.ld_valid = 1'b0;
      end
    end
    chk("mid_fill", 64'(bus.fifo_count), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_we3", 64'(bus.we3), 64'd0);
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_count", 64'(bus.fifo_count), 64'd0);
    chk("mid_ready", 64'(bus.ld_ready), 64'd1);
    idle_in();
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    repeat (6) begin
      tick();
      chk("mid_nowrite", 64'(bus.we3), 64'd0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      bus.alu_valid   = 1'($urandom_range(0, 1));
      bus.alu_wa      = 5'($urandom_range(0, 31));
      bus.alu_wd      = {$urandom, $urandom};
      bus.ld_issue    = ($urandom_range(0, 3) == 0);
      bus.ld_issue_wa = 5'($urandom_range(0, 31));
      if (!bus.ld_valid && $urandom_range(0, 2) == 0)
        offer(5'($urandom_range(0, 31)), {$urandom, $urandom});
      tick();
      if (m_acc) bus.ld_valid = 1'b0;
    end
    idle_in();
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
